alu_mul_sequencer: RTL



---
 rtl/alu_mul_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier sequencer that borrows the shared datapath ALU.
// It drives the ALU operands and control while alu_grant is high. It returns
// the low WIDTH bits of the product together with a one-cycle done pulse.
// Optional feature: define SIGNED_MUL_EN to add the NEG_A/NEG_B/NEG_R states,
// which handle signed operands when mul_signed is set at start.
module alu_mul_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          EARLY_TERM = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mul_signed,
  input  logic [WIDTH-1:0] alu_result,
  output logic             alu_grant,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [2:0]       alu_control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned     CntW   = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

  localparam logic [2:0] AluAdd  = 3'b010;
  localparam logic [2:0] AluSub  = 3'b011;
  localparam logic [2:0] AluNone = 3'b000;

`ifdef SIGNED_MUL_EN
  typedef enum logic [2:0] {
    StIdle, StEval, StAdd, StShift, StDone, StNegA, StNegB, StNegR
  } state_e;
`else
  typedef enum logic [2:0] {StIdle, StEval, StAdd, StShift, StDone} state_e;
`endif

  state_e           r_state;
  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier, r_product;
  logic [WIDTH-1:0] r_src_a, r_src_b;
  logic [CntW-1:0]  r_count;
  logic [2:0]       r_ctl;
  logic             r_grant, r_busy, r_done;
  logic             w_finish;

`ifdef SIGNED_MUL_EN
  logic r_neg_b, r_sign;
  logic w_neg_a, w_neg_b;
  assign w_neg_a = mul_signed & operand_a[WIDTH-1];
  assign w_neg_b = mul_signed & operand_b[WIDTH-1];
`else
  logic w_unused_sign;
  assign w_unused_sign = mul_signed;
`endif

  // Terminate after WIDTH bits, or once no set multiplier bits remain.
  assign w_finish = (r_count == CntMax) || (EARLY_TERM && (r_mplier == '0));

  assign alu_grant   = r_grant;
  assign alu_src_a   = r_src_a;
  assign alu_src_b   = r_src_b;
  assign alu_control = r_ctl;
  assign busy        = r_busy;
  assign done        = r_done;
  assign product     = r_product;

  // Sequencer FSM. The ALU outputs are set on the edge that enters an ALU
  // state, so they are stable for the whole of that state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_src_a   <= '0;
      r_src_b   <= '0;
      r_ctl     <= AluNone;
      r_grant   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef SIGNED_MUL_EN
      r_neg_b   <= 1'b0;
      r_sign    <= 1'b0;
`endif
    end else begin
      r_src_a <= '0;
      r_src_b <= '0;
      r_ctl   <= AluNone;
      r_grant <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_mcand  <= operand_a;
            r_mplier <= operand_b;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
`ifdef SIGNED_MUL_EN
            r_neg_b  <= w_neg_b;
            r_sign   <= w_neg_a ^ w_neg_b;
            if (w_neg_a) begin
              r_state <= StNegA;
              r_grant <= 1'b1;
              r_ctl   <= AluSub;
              r_src_b <= operand_a;
            end else if (w_neg_b) begin
              r_state <= StNegB;
              r_grant <= 1'b1;
              r_ctl   <= AluSub;
              r_src_b <= operand_b;
            end else begin
              r_state <= StEval;
            end
`else
            r_state  <= StEval;
`endif
          end
        end
        StEval: begin
          if (w_finish) begin
`ifdef SIGNED_MUL_EN
            if (r_sign) begin
              r_state <= StNegR;
              r_grant <= 1'b1;
              r_ctl   <= AluSub;
              r_src_b <= r_acc;
            end else begin
              r_state   <= StDone;
              r_done    <= 1'b1;
              r_product <= r_acc;
            end
`else
            r_state   <= StDone;
            r_done    <= 1'b1;
            r_product <= r_acc;
`endif
          end else if (r_mplier[0]) begin
            r_state <= StAdd;
            r_grant <= 1'b1;
            r_ctl   <= AluAdd;
            r_src_a <= r_acc;
            r_src_b <= r_mcand;
          end else begin
            r_state <= StShift;
          end
        end
        StAdd: begin
          r_acc   <= alu_result;
          r_state <= StShift;
        end
        StShift: begin
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CntW'(1);
          r_state  <= StEval;
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
`ifdef SIGNED_MUL_EN
        StNegA: begin
          r_mcand <= alu_result;
          if (r_neg_b) begin
            r_state <= StNegB;
            r_grant <= 1'b1;
            r_ctl   <= AluSub;
            r_src_b <= r_mplier;
          end else begin
            r_state <= StEval;
          end
        end
        StNegB: begin
          r_mplier <= alu_result;
          r_state  <= StEval;
        end
        StNegR: begin
          r_acc     <= alu_result;
          r_product <= alu_result;
          r_done    <= 1'b1;
          r_state   <= StDone;
        end
`endif
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule
